// File: rtl/nx_im_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nx_im_arbiter
// Purpose  : Shares one interface-monitor capture port between N_REQ monitor
//            pipes. Arbitration is round-robin or fixed-priority. The grant is
//            locked for the duration of a packet. The capture stream leaves
//            through a 1-deep output register.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            cfg_fixed         - 1 = fixed priority (index 0 highest), 0 = RR
//            req_vld/last/data - per-pipe beat (pipe i at [i*DW +: DW])
//            req_rdy           - per-pipe accept, one-hot or zero
//            out_vld/data/last - registered capture beat
//            out_src           - index of the pipe that produced out beat
//            out_rdy           - capture buffer accept
//            stat_clr/stat_beats - only when IM_ARB_STATS_EN is defined
// Config   : `define IM_ARB_STATS_EN adds saturating per-pipe beat counters.
// Revision : 1.0 - initial release
// ============================================================================
module nx_im_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 64,
    parameter int SW    = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_fixed,
    input  logic [N_REQ-1:0]    req_vld,
    input  logic [N_REQ-1:0]    req_last,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_rdy,
    output logic                out_vld,
    output logic [DW-1:0]       out_data,
    output logic                out_last,
    output logic [SW-1:0]       out_src,
    input  logic                out_rdy
`ifdef IM_ARB_STATS_EN
    ,
    input  logic                stat_clr,
    output logic [N_REQ*32-1:0] stat_beats
`endif
);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;
    localparam logic [SW-1:0] c_LAST_IDX = SW'(N_REQ - 1);

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic [SW-1:0] r_rr_ptr;
    logic [SW-1:0] w_rr_ptr_nxt;
    logic [SW-1:0] r_owner;
    logic [SW-1:0] w_owner_nxt;

    logic [SW-1:0] w_rr_sel;
    logic          w_rr_hit;
    logic [SW-1:0] w_fix_sel;
    logic [SW-1:0] w_sel;
    logic          w_adv;
    logic          w_accept;
    logic          w_acc_last;
    logic [DW-1:0] w_sel_data;

    logic          r_out_vld;
    logic [DW-1:0] r_out_data;
    logic          r_out_last;
    logic [SW-1:0] r_out_src;

    function automatic logic [SW-1:0] f_wrap_inc(input logic [SW-1:0] v);
        return (v == c_LAST_IDX) ? '0 : v + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Winner selection among valid requesters
    // ------------------------------------------------------------------
    always_comb begin : p_winner
        int v_idx;
        v_idx     = 0;
        w_rr_sel  = '0;
        w_rr_hit  = 1'b0;
        w_fix_sel = '0;
        // Scanning downwards leaves the lowest asserted index selected.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_vld[k]) begin
                w_fix_sel = SW'(k);
            end
        end
        // Round-robin: first asserted index at or after rr_ptr, wrapping.
        for (int k = 0; k < N_REQ; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= N_REQ) begin
                v_idx = v_idx - N_REQ;
            end
            if (!w_rr_hit && req_vld[v_idx]) begin
                w_rr_hit = 1'b1;
                w_rr_sel = SW'(v_idx);
            end
        end
    end

    // While locked only the owner may move, regardless of cfg_fixed.
    assign w_sel      = (r_state == c_ST_LOCKED) ? r_owner
                      : (cfg_fixed ? w_fix_sel : w_rr_sel);
    assign w_adv      = ~r_out_vld | out_rdy;
    assign w_accept   = |(req_vld & req_rdy);
    assign w_acc_last = req_last[w_sel];
    assign w_sel_data = req_data[w_sel*DW +: DW];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_owner  <= w_owner_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_owner_nxt  = r_owner;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    if (w_acc_last) begin
                        w_rr_ptr_nxt = f_wrap_inc(w_sel);
                    end else begin
                        w_state_nxt = c_ST_LOCKED;
                        w_owner_nxt = w_sel;
                    end
                end
            end
            c_ST_LOCKED: begin
                if (w_accept && w_acc_last) begin
                    w_state_nxt  = c_ST_IDLE;
                    w_rr_ptr_nxt = f_wrap_inc(r_owner);
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. A locked owner is granted even on a bubble so that
    // the other pipes keep waiting; in IDLE the grant needs a valid beat.
    // ------------------------------------------------------------------
    always_comb begin
        req_rdy = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_rdy[i] = ~rst & w_adv & (w_sel == SW'(i))
                       & ((r_state == c_ST_LOCKED) | req_vld[i]);
        end
    end

    // ------------------------------------------------------------------
    // 1-deep output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
            r_out_src  <= '0;
        end else if (w_accept) begin
            r_out_vld  <= 1'b1;
            r_out_data <= w_sel_data;
            r_out_last <= w_acc_last;
            r_out_src  <= w_sel;
        end else if (w_adv) begin
            r_out_vld  <= 1'b0;
        end
    end

    assign out_vld  = r_out_vld;
    assign out_data = r_out_data;
    assign out_last = r_out_last;
    assign out_src  = r_out_src;

`ifdef IM_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating per-pipe accepted-beat counters
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stats
            logic [31:0] r_cnt;
            logic        w_acc;
            assign w_acc = req_vld[gi] & req_rdy[gi];
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (stat_clr) begin
                    r_cnt <= w_acc ? 32'd1 : 32'd0;
                end else if (w_acc && (r_cnt != 32'hFFFF_FFFF)) begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
            assign stat_beats[gi*32 +: 32] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_nx_im_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nx_im_arbiter
// Purpose  : Directed self-checking bench for nx_im_arbiter (N_REQ=4, DW=64).
//            Pipe data encodes {requester, beat sequence}; a per-source
//            scoreboard catches dropped or duplicated beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nx_im_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_fixed = 1'b0;
    logic [N-1:0]    req_vld = '0;
    logic [N-1:0]    req_last = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_rdy;
    logic            out_vld;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [1:0]      out_src;
    logic            out_rdy = 1'b1;
`ifdef IM_ARB_STATS_EN
    logic            stat_clr = 1'b0;
    logic [N*32-1:0] stat_beats;
`endif

    nx_im_arbiter #(.N_REQ(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_fixed (cfg_fixed),
        .req_vld   (req_vld),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_rdy   (req_rdy),
        .out_vld   (out_vld),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_rdy   (out_rdy)
`ifdef IM_ARB_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_beats(stat_beats)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] seq [N];   // next beat sequence each pipe presents
    logic [31:0] sb  [N];   // next beat sequence expected on out per source

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [N-1:0] vld, input logic [N-1:0] last, input logic ordy);
        req_vld  = vld;
        req_last = last;
        out_rdy  = ordy;
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = {32'(i), seq[i]};
        end
    endtask

    // One cycle: drive, check grant, clock, then check the registered beat.
    task automatic step(input logic [N-1:0] vld, input logic [N-1:0] last,
                        input logic ordy, input logic [N-1:0] exp_rdy,
                        input logic exp_ov, input logic exp_ol, input int exp_src);
        logic [N-1:0] acc;
        logic         cons;
        int           csrc;
        drive(vld, last, ordy);
        #1;
        chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
        acc  = req_vld & req_rdy;
        cons = out_vld & out_rdy;
        csrc = int'(out_src);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) seq[i] = seq[i] + 1;
        end
        if (cons) sb[csrc] = sb[csrc] + 1;
        chk("out_vld", 64'(out_vld), 64'(exp_ov));
        if (exp_ov) begin
            chk("out_src", 64'(out_src), 64'(exp_src));
            chk("out_last", 64'(out_last), 64'(exp_ol));
            chk("out_data", out_data, {32'(exp_src), sb[exp_src]});
        end
    endtask

    task automatic do_reset(input logic [N-1:0] vld);
        rst = 1'b1;
        drive(vld, '0, 1'b1);
        #1;
        chk("rst_rdy", 64'(req_rdy), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_vld", 64'(out_vld), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_src", 64'(out_src), 64'd0);
`ifdef IM_ARB_STATS_EN
        chk("rst_stat_lo", stat_beats[63:0], 64'd0);
        chk("rst_stat_hi", stat_beats[127:64], 64'd0);
`endif
        rst = 1'b0;
        for (int i = 0; i < N; i++) sb[i] = seq[i];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            seq[i] = 32'd0;
            sb[i]  = 32'd0;
        end
        @(posedge clk);
        #1;
        do_reset(4'b1111);

        // 1: single 3-beat packet from pipe 0
        step(4'b0001, 4'b0000, 1, 4'b0001, 1, 0, 0);
        step(4'b0001, 4'b0000, 1, 4'b0001, 1, 0, 0);
        step(4'b0001, 4'b0001, 1, 4'b0001, 1, 1, 0);
        step(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);

        // 2: round-robin over four 1-beat requesters
        do_reset(4'b0000);
        step(4'b1111, 4'b1111, 1, 4'b0001, 1, 1, 0);
        step(4'b1111, 4'b1111, 1, 4'b0010, 1, 1, 1);
        step(4'b1111, 4'b1111, 1, 4'b0100, 1, 1, 2);
        step(4'b1111, 4'b1111, 1, 4'b1000, 1, 1, 3);
        step(4'b1111, 4'b1111, 1, 4'b0001, 1, 1, 0);
        step(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);

        // 3: lock held across a 2-cycle bubble while pipe 1 waits
        do_reset(4'b0000);
        step(4'b0011, 4'b0010, 1, 4'b0001, 1, 0, 0);
        step(4'b0010, 4'b0010, 1, 4'b0001, 0, 0, 0);
        step(4'b0010, 4'b0010, 1, 4'b0001, 0, 0, 0);
        step(4'b0011, 4'b0010, 1, 4'b0001, 1, 0, 0);
        step(4'b0011, 4'b0010, 1, 4'b0001, 1, 0, 0);
        step(4'b0011, 4'b0011, 1, 4'b0001, 1, 1, 0);
        step(4'b0010, 4'b0010, 1, 4'b0010, 1, 1, 1);
        step(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);

        // 4: five cycles of backpressure inside a packet from pipe 2
        do_reset(4'b0000);
        step(4'b0100, 4'b0000, 1, 4'b0100, 1, 0, 2);
        for (int c = 0; c < 5; c++) begin
            step(4'b0100, 4'b0000, 0, 4'b0000, 1, 0, 2);
        end
        step(4'b0100, 4'b0000, 1, 4'b0100, 1, 0, 2);
        step(4'b0100, 4'b0100, 1, 4'b0100, 1, 1, 2);
        step(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);

        // 5: fixed priority, then switch to RR during a locked packet
        do_reset(4'b0000);
        cfg_fixed = 1'b1;
        step(4'b0101, 4'b0101, 1, 4'b0001, 1, 1, 0);
        step(4'b0101, 4'b0101, 1, 4'b0001, 1, 1, 0);
        step(4'b0101, 4'b0101, 1, 4'b0001, 1, 1, 0);
        step(4'b0101, 4'b0100, 1, 4'b0001, 1, 0, 0);
        cfg_fixed = 1'b0;
        step(4'b0101, 4'b0100, 1, 4'b0001, 1, 0, 0);
        step(4'b0101, 4'b0101, 1, 4'b0001, 1, 1, 0);
        step(4'b0101, 4'b0101, 1, 4'b0100, 1, 1, 2);
        step(4'b0101, 4'b0101, 1, 4'b0001, 1, 1, 0);
        step(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);

        // 6: reset while locked on pipe 3, then pipe 1 wins from rr_ptr=0
        do_reset(4'b0000);
        step(4'b1000, 4'b0000, 1, 4'b1000, 1, 0, 3);
        step(4'b1000, 4'b0000, 1, 4'b1000, 1, 0, 3);
        do_reset(4'b1010);
        step(4'b1010, 4'b1010, 1, 4'b0010, 1, 1, 1);
        step(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
